// File: rtl/branch_predictor_if.sv
// -----------------------------------------------------------------------------
// branch_predictor_if
//
// Purpose : bundles the fetch-side lookup, the resolve-side training port and
//           the performance counters of the branch predictor into one bus.
//
// Modports:
//   master - pipeline side. It drives lookup_pc and the upd_* fields, and it
//            reads the prediction and the perf counters.
//   slave  - predictor side (branch_predictor). It is the reverse of master.
//
// Signals:
//   lookup_pc      [31:0]          fetch-stage PC
//   pred_hit                       valid entry with a matching tag
//   pred_taken                     predicted taken
//   pred_target    [31:0]          predicted next PC
//   upd_valid                      a resolved branch/jump is presented
//   upd_pc         [31:0]          PC of the resolved instruction
//   upd_taken                      actual outcome
//   upd_target     [31:0]          actual taken target
//   upd_pred_taken                 prediction carried down the pipe
//   perf_branches  [CNT_WIDTH-1:0] saturating count of updates
//   perf_mispred   [CNT_WIDTH-1:0] saturating count of direction mispredicts
// -----------------------------------------------------------------------------
interface branch_predictor_if #(
    parameter int CNT_WIDTH = 16
);
    logic [31:0]          lookup_pc;
    logic                 pred_hit;
    logic                 pred_taken;
    logic [31:0]          pred_target;

    logic                 upd_valid;
    logic [31:0]          upd_pc;
    logic                 upd_taken;
    logic [31:0]          upd_target;
    logic                 upd_pred_taken;

    logic [CNT_WIDTH-1:0] perf_branches;
    logic [CNT_WIDTH-1:0] perf_mispred;

    modport master (
        output lookup_pc,
        output upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
        input  pred_hit, pred_taken, pred_target,
        input  perf_branches, perf_mispred
    );

    modport slave (
        input  lookup_pc,
        input  upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
        output pred_hit, pred_taken, pred_target,
        output perf_branches, perf_mispred
    );
endinterface

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Purpose : a direct-mapped branch target buffer with 2-bit saturating
//           direction counters. It gives the fetch stage a same-cycle
//           next-PC prediction. The resolve stage trains it with at most one
//           update per cycle. Two saturating counters record the number of
//           resolved branches and the number of direction mispredicts.
//
// Parameters:
//   ENTRIES   number of BTB entries (power of two, 2..256)
//   TAG_WIDTH stored tag bits per entry (IDX_BITS + TAG_WIDTH <= 30)
//   CNT_WIDTH width of each performance counter (must match the interface)
//
// Ports:
//   clk    rising-edge clock for all state
//   reset  asynchronous, active-high; clears every entry and both counters
//   bp     branch_predictor_if.slave: lookup, update and perf signals
//
// Address split: index = pc[IDX_BITS+1:2], tag = pc[IDX_BITS+TAG_WIDTH+1:IDX_BITS+2].
// PCs that share an index and a tag alias onto one entry. This is expected.
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int ENTRIES   = 16,
    parameter int TAG_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    branch_predictor_if.slave  bp
);

    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int IDX_LSB  = 2;
    localparam int TAG_LSB  = IDX_BITS + 2;

    // Direction counter encoding. Bit 1 is the taken prediction.
    localparam logic [1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] CTR_WEAK_T    = 2'b10;
    localparam logic [1:0] CTR_STRONG_T  = 2'b11;

    typedef logic [IDX_BITS-1:0]  idx_t;
    typedef logic [TAG_WIDTH-1:0] tag_t;
    typedef logic [CNT_WIDTH-1:0] cnt_t;

    typedef struct packed {
        logic        valid;
        tag_t        tag;
        logic [31:0] target;
        logic [1:0]  ctr;
    } entry_t;

    localparam entry_t ENTRY_RESET = '{
        valid:  1'b0,
        tag:    '0,
        target: 32'd0,
        ctr:    CTR_WEAK_NT
    };

    entry_t entry_q [ENTRIES];

    // -------------------------------------------------------------------------
    // Lookup path (purely combinational, no bypass of a same-cycle update)
    // -------------------------------------------------------------------------
    idx_t   lk_idx;
    tag_t   lk_tag;
    entry_t lk_entry;
    logic   lk_hit;
    logic   lk_taken;

    assign lk_idx   = bp.lookup_pc[IDX_BITS+IDX_LSB-1:IDX_LSB];
    assign lk_tag   = bp.lookup_pc[TAG_WIDTH+TAG_LSB-1:TAG_LSB];
    assign lk_entry = entry_q[lk_idx];
    assign lk_hit   = lk_entry.valid && (lk_entry.tag == lk_tag);
    assign lk_taken = lk_hit && lk_entry.ctr[1];

    assign bp.pred_hit    = lk_hit;
    assign bp.pred_taken  = lk_taken;
    assign bp.pred_target = lk_taken ? lk_entry.target : (bp.lookup_pc + 32'd4);

    // -------------------------------------------------------------------------
    // Update path: compute the new contents of the entry at upd_pc's index
    // -------------------------------------------------------------------------
    idx_t   upd_idx;
    tag_t   upd_tag;
    entry_t upd_entry;
    logic   upd_hit;
    entry_t upd_entry_d;
    logic   upd_write_d;

    assign upd_idx   = bp.upd_pc[IDX_BITS+IDX_LSB-1:IDX_LSB];
    assign upd_tag   = bp.upd_pc[TAG_WIDTH+TAG_LSB-1:TAG_LSB];
    assign upd_entry = entry_q[upd_idx];
    assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

    always_comb begin
        // NOTE: every output of this block gets a default first. A path that
        // does not assign it would otherwise infer a latch.
        upd_entry_d = upd_entry;
        upd_write_d = 1'b0;

        if (bp.upd_valid) begin
            if (upd_hit) begin
                upd_write_d = 1'b1;
                if (bp.upd_taken) begin
                    upd_entry_d.target = bp.upd_target;
                    if (upd_entry.ctr != CTR_STRONG_T) begin
                        upd_entry_d.ctr = upd_entry.ctr + 2'd1;
                    end
                end else if (upd_entry.ctr != CTR_STRONG_NT) begin
                    upd_entry_d.ctr = upd_entry.ctr - 2'd1;
                end
            end else if (bp.upd_taken) begin
                // A taken miss takes the slot and evicts whatever was there.
                // A not-taken miss is not allocated, because it would only
                // predict fall-through, which is the default anyway.
                upd_write_d        = 1'b1;
                upd_entry_d.valid  = 1'b1;
                upd_entry_d.tag    = upd_tag;
                upd_entry_d.target = bp.upd_target;
                upd_entry_d.ctr    = CTR_WEAK_T;
            end
        end
    end

    // NOTE: the table is kept in flops rather than RAM so that an
    // asynchronous reset can clear every entry at once. A RAM macro cannot be
    // reset this way.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_q[i] <= ENTRY_RESET;
            end
        end else if (upd_write_d) begin
            // NOTE: sequential state uses non-blocking assignments. Every
            // flop then samples pre-edge values, whatever the block order.
            entry_q[upd_idx] <= upd_entry_d;
        end
    end

    // -------------------------------------------------------------------------
    // Performance counters: they saturate at all-ones and never wrap
    // -------------------------------------------------------------------------
    cnt_t perf_branches_q, perf_branches_d;
    cnt_t perf_mispred_q,  perf_mispred_d;
    logic mispredict;

    assign mispredict = bp.upd_taken != bp.upd_pred_taken;

    always_comb begin
        perf_branches_d = perf_branches_q;
        perf_mispred_d  = perf_mispred_q;
        if (bp.upd_valid) begin
            if (!(&perf_branches_q)) begin
                perf_branches_d = perf_branches_q + CNT_WIDTH'(1);
            end
            if (mispredict && !(&perf_mispred_q)) begin
                perf_mispred_d = perf_mispred_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_branches_q <= '0;
            perf_mispred_q  <= '0;
        end else begin
            perf_branches_q <= perf_branches_d;
            perf_mispred_q  <= perf_mispred_d;
        end
    end

    assign bp.perf_branches = perf_branches_q;
    assign bp.perf_mispred  = perf_mispred_q;

    // The low PC bits and the bits above the tag do not take part in
    // indexing. They are collected here so that the lint knows this is on
    // purpose.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.lookup_pc, bp.upd_pc};

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Self-checking bench for branch_predictor. It builds two instances that get
// the same stimulus: one with 16-bit perf counters and one with 2-bit perf
// counters, so that counter saturation is reached early. The expected values
// come from a behavioural model of the table, held as plain integer arrays.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int ENTRIES   = 16;
    localparam int TAG_WIDTH = 8;
    localparam int IDX_BITS  = 4;
    localparam int MAX16     = 65535;
    localparam int MAX2      = 3;

    logic clk;
    logic reset;

    int total = 0;
    int bad   = 0;

    branch_predictor_if #(.CNT_WIDTH(16)) bp16 ();
    branch_predictor_if #(.CNT_WIDTH(2))  bp2 ();

    branch_predictor #(.ENTRIES(ENTRIES), .TAG_WIDTH(TAG_WIDTH), .CNT_WIDTH(16)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bp    (bp16.slave)
    );

    branch_predictor #(.ENTRIES(ENTRIES), .TAG_WIDTH(TAG_WIDTH), .CNT_WIDTH(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bp    (bp2.slave)
    );

    assign bp2.lookup_pc      = bp16.lookup_pc;
    assign bp2.upd_valid      = bp16.upd_valid;
    assign bp2.upd_pc         = bp16.upd_pc;
    assign bp2.upd_taken      = bp16.upd_taken;
    assign bp2.upd_target     = bp16.upd_target;
    assign bp2.upd_pred_taken = bp16.upd_pred_taken;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    bit          m_valid [ENTRIES];
    int          m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    int          m_br;
    int          m_mis;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc >> (2 + IDX_BITS)) % (1 << TAG_WIDTH));
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = 32'd0;
            m_ctr[i]   = 1;
        end
        m_br  = 0;
        m_mis = 0;
    endfunction

    function automatic void model_lookup(input logic [31:0] pc, output logic hit,
                                         output logic taken, output logic [31:0] tgt);
        int i;
        i     = idx_of(pc);
        hit   = m_valid[i] && (m_tag[i] == tag_of(pc));
        taken = hit && (m_ctr[i] >= 2);
        tgt   = taken ? m_tgt[i] : pc + 32'd4;
    endfunction

    function automatic void model_update(input logic [31:0] pc, input logic taken,
                                         input logic [31:0] tgt, input logic pred);
        int  i;
        bit  hit;
        i   = idx_of(pc);
        hit = m_valid[i] && (m_tag[i] == tag_of(pc));
        if (hit && taken) begin
            m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            m_tgt[i] = tgt;
        end else if (hit) begin
            m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end else if (taken) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = tag_of(pc);
            m_tgt[i]   = tgt;
            m_ctr[i]   = 2;
        end
        m_br++;
        if (taken != pred) m_mis++;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_perf(input string tag);
        int e16, e2, m16, m2;
        e16 = (m_br  > MAX16) ? MAX16 : m_br;
        m16 = (m_mis > MAX16) ? MAX16 : m_mis;
        e2  = (m_br  > MAX2)  ? MAX2  : m_br;
        m2  = (m_mis > MAX2)  ? MAX2  : m_mis;
        check({tag, "_br16"},  {16'd0, bp16.perf_branches}, 32'(e16));
        check({tag, "_mis16"}, {16'd0, bp16.perf_mispred},  32'(m16));
        check({tag, "_br2"},   {30'd0, bp2.perf_branches},  32'(e2));
        check({tag, "_mis2"},  {30'd0, bp2.perf_mispred},   32'(m2));
    endtask

    task automatic check_lookup(input string tag, input logic [31:0] pc);
        logic eh, et;
        logic [31:0] eg;
        model_lookup(pc, eh, et, eg);
        check({tag, "_hit"},    {31'd0, bp16.pred_hit},   {31'd0, eh});
        check({tag, "_taken"},  {31'd0, bp16.pred_taken}, {31'd0, et});
        check({tag, "_target"}, bp16.pred_target,         eg);
    endtask

    // One clock cycle. Drive the inputs, check the lookup against the
    // pre-update model at the falling edge, then let the rising edge update.
    task automatic cycle(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                         input logic ut, input logic [31:0] utgt, input logic upt);
        bp16.lookup_pc      = lpc;
        bp16.upd_valid      = uv;
        bp16.upd_pc         = upc;
        bp16.upd_taken      = ut;
        bp16.upd_target     = utgt;
        bp16.upd_pred_taken = upt;
        @(negedge clk);
        check_lookup("cyc", lpc);
        check_perf("cyc");
        @(posedge clk);
        if (uv) model_update(upc, ut, utgt, upt);
        #1;
    endtask

    // Lookup-only probe with explicit expected values, taken between edges.
    task automatic peek(input string tag, input logic [31:0] pc, input logic eh,
                        input logic et, input logic [31:0] eg);
        bp16.lookup_pc = pc;
        bp16.upd_valid = 1'b0;
        #1;
        check({tag, "_hit"},    {31'd0, bp16.pred_hit},   {31'd0, eh});
        check({tag, "_taken"},  {31'd0, bp16.pred_taken}, {31'd0, et});
        check({tag, "_target"}, bp16.pred_target,         eg);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        pc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
        if ($urandom_range(0, 7) == 0) pc = pc | ($urandom & 32'hFFFF_C000);
        return pc;
    endfunction

    initial begin
        bp16.lookup_pc      = 32'h40;
        bp16.upd_valid      = 1'b0;
        bp16.upd_pc         = 32'd0;
        bp16.upd_taken      = 1'b0;
        bp16.upd_target     = 32'd0;
        bp16.upd_pred_taken = 1'b0;
        model_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        peek("rst", 32'h40, 1'b0, 1'b0, 32'h44);
        check_perf("rst");

        // Allocate 0x40 -> 0x100. This is a mispredict.
        cycle(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
        peek("alloc", 32'h40, 1'b1, 1'b1, 32'h100);
        check("alloc_br",  {16'd0, bp16.perf_branches}, 32'd1);
        check("alloc_mis", {16'd0, bp16.perf_mispred},  32'd1);

        // Two not-taken: 2 -> 1 -> 0
        cycle(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
        cycle(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        peek("ctr0", 32'h40, 1'b1, 1'b0, 32'h44);

        // Four taken (0 -> 1 -> 2 -> 3 -> 3), then one not-taken -> 2
        repeat (4) cycle(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
        cycle(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
        peek("ctr2", 32'h40, 1'b1, 1'b1, 32'h100);

        // Same index, different tag: it misses, then it evicts
        peek("alias", 32'h80, 1'b0, 1'b0, 32'h84);
        cycle(32'h80, 1'b1, 32'h80, 1'b1, 32'h300, 1'b0);
        peek("evicted", 32'h40, 1'b0, 1'b0, 32'h44);
        peek("newocc",  32'h80, 1'b1, 1'b1, 32'h300);

        // Re-allocate 0x40, then do an update and a lookup in the same cycle
        cycle(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
        bp16.lookup_pc = 32'h40; bp16.upd_valid = 1'b1; bp16.upd_pc = 32'h40;
        bp16.upd_taken = 1'b1; bp16.upd_target = 32'h200; bp16.upd_pred_taken = 1'b1;
        @(negedge clk);
        check("bypass_old", bp16.pred_target, 32'h100);
        @(posedge clk);
        model_update(32'h40, 1'b1, 32'h200, 1'b1);
        #1;
        peek("bypass_new", 32'h40, 1'b1, 1'b1, 32'h200);
        check("sat2_mis", {30'd0, bp2.perf_mispred}, 32'd3);
        check_perf("mid");

        // Asynchronous reset in the middle of an update
        bp16.upd_valid = 1'b1; bp16.upd_pc = 32'h40; bp16.upd_taken = 1'b1;
        bp16.upd_target = 32'h500;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_hit",    {31'd0, bp16.pred_hit}, 32'd0);
        check("arst_target", bp16.pred_target, 32'h44);
        check("arst_br",     {16'd0, bp16.perf_branches}, 32'd0);
        check("arst_mis2",   {30'd0, bp2.perf_mispred},   32'd0);
        @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;
        peek("post_rst", 32'h40, 1'b0, 1'b0, 32'h44);

        // Random traffic checked against the model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] upc, lpc;
            logic eh, et, upt;
            logic [31:0] eg;
            upc = rand_pc();
            lpc = ($urandom_range(0, 3) == 0) ? upc : rand_pc() | 32'($urandom_range(0, 3));
            model_lookup(upc, eh, et, eg);
            upt = ($urandom_range(0, 3) == 0) ? 1'($urandom) : et;
            cycle(lpc, 1'($urandom_range(0, 4) != 0), upc, 1'($urandom_range(0, 2) != 0),
                  $urandom & 32'hFFFF_FFFC, upt);
        end
        @(negedge clk);
        check_perf("end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch target buffer with 2-bit saturating direction counters for the pipelined MIPS core. It gives the fetch stage a same-cycle prediction of next PC and replaces the fixed "predict not-taken, flush on resolve" policy. The branch/jump resolution logic trains it one update per cycle. It also keeps saturating mispredict and branch counters for performance measurement.

## Interface
- ENTRIES, 16, number of BTB entries; power of two, 2..256
- TAG_WIDTH, 8, stored tag bits per entry; IDX_BITS + TAG_WIDTH ≤ 30
- CNT_WIDTH, 16, width of each performance counter
- IDX_BITS (derived, log2(ENTRIES)): index = pc[IDX_BITS+1:2], tag = pc[IDX_BITS+TAG_WIDTH+1:IDX_BITS+2]

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- lookup_pc  in  32  fetch-stage PC
- pred_hit  out  1  valid entry with matching tag at lookup_pc
- pred_taken  out  1  predicted taken
- pred_target  out  32  predicted next PC
- upd_valid  in  1  a resolved branch/jump is presented this cycle
- upd_pc  in  32  PC of the resolved instruction
- upd_taken  in  1  actual outcome; jumps always 1
- upd_target  in  32  actual taken target
- upd_pred_taken  in  1  pred_taken carried down the pipe for this instruction
- perf_branches  out  CNT_WIDTH  count of upd_valid cycles, saturating
- perf_mispred  out  CNT_WIDTH  count of direction mispredicts, saturating

## Operation
- Each entry holds valid (1b), tag (TAG_WIDTH), target (32b) and ctr (2b).
- Entries are held in flops so reset can clear them asynchronously.
- Lookup (combinational from lookup_pc):
  - pred_hit = valid[i] & (tag[i] == lookup tag)
  - pred_taken = pred_hit & ctr[i][1]
  - pred_target = target[i] when pred_taken, else lookup_pc + 4, mod 2^32
- Update, on the rising edge with upd_valid = 1, at index j from upd_pc:
  - Hit, taken: ctr saturating increment (3 stays 3); target ← upd_target.
  - Hit, not taken: ctr saturating decrement (0 stays 0); target unchanged.
  - Miss, taken: allocate, replacing any occupant. valid ← 1, tag ← upd tag, target ← upd_target, ctr ← 2'b10 (weakly taken).
  - Miss, not taken: no change to entry j.
- Counter states: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T. Prediction is taken for states 2 and 3.
- Performance counters, on upd_valid:
  - perf_branches increments.
  - perf_mispred increments when upd_taken != upd_pred_taken.
  - Both hold at all-ones once reached; there is no wrap.
- Aliasing: PCs sharing index and tag share one entry. This is accepted, not detected.

## Timing
- Reset (asynchronous, any time, including mid-update):
  - all valid = 0, all ctr = 2'b01, all target = 0, tag = 0
  - perf counters = 0
  - outputs immediately: pred_hit = 0, pred_taken = 0, pred_target = lookup_pc + 4
- Lookup latency: 0 cycles (pure combinational).
- Update latency: the write takes effect at the edge where upd_valid is sampled and is visible to lookups from the next cycle.
- Same-cycle lookup and update to the same entry: the lookup returns pre-update state. There is no bypass.
- Throughput: one update per cycle, back-to-back. Consecutive updates to the same entry compound: two taken updates from ctr = 1 end at 3.
- Inputs other than reset are sampled only at clk rising edge. upd_* are don't-care when upd_valid = 0.

## Test plan
- Reset, then lookup_pc = 0x40 -> pred_hit 0, pred_taken 0, pred_target 0x44; perf counters 0.
- Update pc 0x40, taken, target 0x100, pred_taken 0 -> next cycle lookup 0x40 gives hit 1, taken 1, target 0x100. perf_branches 1, perf_mispred 1.
- After allocation, two not-taken updates at 0x40 -> ctr 2→1→0, pred_taken 0, pred_hit 1. Three taken updates -> ctr 1,2,3, then a fourth stays 3. One not-taken then leaves ctr at 2 and pred_taken 1.
- ENTRIES = 16: allocate 0x40, then lookup 0x80 (same index, different tag) -> hit 0. Taken update at 0x80 evicts it, and lookup 0x40 then gives hit 0.
- Same-cycle update (taken, new target 0x200) and lookup of 0x40 with old target 0x100 -> that cycle shows 0x100, the next cycle shows 0x200.
- Assert reset mid-stream with populated entries -> hits drop to 0 combinationally. With CNT_WIDTH = 2, four mispredicts leave perf_mispred at 3.
